// File: rtl/seq_check_param.sv
// ---------------------------------------------------------------------------
// seq_check_param
//   Parametrised serial-pattern detector. Each accepted beat carries IN_W
//   stream bits, with data_in[IN_W-1] the earliest on the stream. Every
//   alignment that ends inside the beat is compared with a runtime SEQ_LEN-bit
//   pattern. Overlapping or non-overlapping detection is selectable, and a
//   saturating hit counter is kept.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   clr       in   1        synchronous flush of history, fill and hit count;
//                           wins over valid, and a beat presented with it is
//                           discarded
//   valid     in   1        data_in holds a beat this cycle
//   data_in   in   IN_W     beat, MSB first on the stream
//   pattern   in   SEQ_LEN  pattern, pattern[SEQ_LEN-1] is the first bit
//   overlap   in   1        1: overlapping matches, 0: a match consumes bits
//   flag_out  out  1        some hit in the previous valid beat
//   hit_vec   out  IN_W     hit_vec[k]: match completed at data_in[k]
//   hit_cnt   out  CNT_W    saturating hit total since reset/clr
//
// Handshake: there is no back-pressure. A beat is accepted on every rising
// edge where valid=1 and clr=0. flag_out/hit_vec describe that beat one
// cycle later and read 0 after any cycle without an accepted beat.
// ---------------------------------------------------------------------------
module seq_check_param #(
  parameter int IN_W    = 2,
  parameter int SEQ_LEN = 7,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               valid,
  input  logic [IN_W-1:0]    data_in,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               flag_out,
  output logic [IN_W-1:0]    hit_vec,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int HW     = SEQ_LEN - 1;
  localparam int WIN_W  = HW + IN_W;
  localparam int FILL_W = $clog2(SEQ_LEN);
  // Wide enough for the largest counter value plus a full beat of hits.
  localparam int SUM_W  = CNT_W + $clog2(IN_W + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [HW-1:0]     hist;
  logic [FILL_W-1:0] fill;

  logic [WIN_W-1:0]  window;
  logic [IN_W-1:0]   raw_hit;
  logic [IN_W-1:0]   first_hit;
  logic [IN_W-1:0]   hit_next;
  logic [HW-1:0]     hist_next;
  logic [FILL_W-1:0] fill_next;
  logic [HW-1:0]     ones;
  logic [SUM_W-1:0]  pop;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_next;
  int                first_k;

  always_comb begin
    window    = {hist, data_in};
    raw_hit   = '0;
    first_hit = '0;
    first_k   = 0;
    ones      = '1;

    // Alignment k ends at data_in[k]; it is only eligible once enough real
    // bits sit behind it, so reset zeros in hist can never fake a match.
    for (int k = 0; k < IN_W; k++) begin
      if ((int'(fill) + IN_W - k >= SEQ_LEN) &&
          (window[k +: SEQ_LEN] == pattern)) begin
        raw_hit[k] = 1'b1;
      end
    end

    // Earliest hit on the stream is the highest k; ascending scan, last wins.
    for (int k = 0; k < IN_W; k++) begin
      if (raw_hit[k]) begin
        first_hit    = '0;
        first_hit[k] = 1'b1;
        first_k      = k;
      end
    end

    hit_next = overlap ? raw_hit : first_hit;

    if (!overlap && (|raw_hit)) begin
      // The match consumes everything up to and including data_in[first_k];
      // only the later bits data_in[first_k-1:0] survive as fresh history.
      hist_next = window[HW-1:0] & (ones >> (HW - first_k));
      fill_next = FILL_W'(first_k);
    end else begin
      hist_next = window[HW-1:0];
      fill_next = (int'(fill) + IN_W >= HW) ? FILL_W'(HW) : FILL_W'(int'(fill) + IN_W);
    end

    pop = '0;
    for (int k = 0; k < IN_W; k++) begin
      pop = pop + SUM_W'(hit_next[k]);
    end
    cnt_sum  = SUM_W'(hit_cnt) + pop;
    cnt_next = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      fill     <= '0;
      flag_out <= 1'b0;
      hit_vec  <= '0;
      hit_cnt  <= '0;
    end else if (clr) begin
      hist     <= '0;
      fill     <= '0;
      flag_out <= 1'b0;
      hit_vec  <= '0;
      hit_cnt  <= '0;
    end else if (valid) begin
      hist     <= hist_next;
      fill     <= fill_next;
      flag_out <= |hit_next;
      hit_vec  <= hit_next;
      hit_cnt  <= cnt_next;
    end else begin
      flag_out <= 1'b0;
      hit_vec  <= '0;
    end
  end

endmodule

// File: tb/tb_seq_check_param.sv
// ---------------------------------------------------------------------------
// tb_seq_check_param
//   Directed scenarios followed by randomized traffic for seq_check_param.
//   Expected values come from a bit-serial reference model: a queue of the
//   accepted stream bits plus a count of bits still allowed to start a match.
//   A second instance with CNT_W=2 shares the stimulus to exercise counter
//   saturation.
// ---------------------------------------------------------------------------
module tb_seq_check_param;

  localparam int IN_W    = 2;
  localparam int SEQ_LEN = 7;
  localparam int CNT_W   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               clr = 1'b0;
  logic               valid = 1'b0;
  logic [IN_W-1:0]    data_in = '0;
  logic [SEQ_LEN-1:0] pattern = '0;
  logic               overlap = 1'b1;

  logic               flag_out;
  logic [IN_W-1:0]    hit_vec;
  logic [CNT_W-1:0]   hit_cnt;
  logic               s_flag;
  logic [IN_W-1:0]    s_vec;
  logic [1:0]         s_cnt;

  seq_check_param #(.IN_W(IN_W), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .data_in(data_in),
    .pattern(pattern), .overlap(overlap),
    .flag_out(flag_out), .hit_vec(hit_vec), .hit_cnt(hit_cnt)
  );

  seq_check_param #(.IN_W(IN_W), .SEQ_LEN(SEQ_LEN), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .data_in(data_in),
    .pattern(pattern), .overlap(overlap),
    .flag_out(s_flag), .hit_vec(s_vec), .hit_cnt(s_cnt)
  );

  int checks = 0;
  int errors = 0;
  int flag_seen = 0;

  // reference model state
  bit              model_bits[$];
  int              avail;
  int              exp_cnt;
  logic [IN_W-1:0] exp_vec;
  logic            exp_flag;

  task automatic model_clear();
    model_bits.delete();
    avail    = 0;
    exp_cnt  = 0;
    exp_vec  = '0;
    exp_flag = 1'b0;
  endtask

  // Walk the beat bit by bit in stream order; a bit completes a match when at
  // least SEQ_LEN usable bits end at it and they spell the pattern.
  task automatic model_beat(input logic [IN_W-1:0] d);
    logic hit_seen;
    logic match;
    hit_seen = 1'b0;
    exp_vec  = '0;
    for (int i = 0; i < IN_W; i++) begin
      model_bits.push_back(d[IN_W-1-i]);
      if (model_bits.size() > SEQ_LEN) void'(model_bits.pop_front());
      avail++;
      if (avail >= SEQ_LEN && !(hit_seen && !overlap)) begin
        match = 1'b1;
        for (int j = 0; j < SEQ_LEN; j++)
          if (model_bits[j] != pattern[SEQ_LEN-1-j]) match = 1'b0;
        if (match) begin
          exp_vec[IN_W-1-i] = 1'b1;
          hit_seen = 1'b1;
          exp_cnt++;
          if (!overlap) avail = 0;
        end
      end
    end
    exp_flag = |exp_vec;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_flag"}, 32'(flag_out), 32'(exp_flag));
    check_val({tag, "_vec"},  32'(hit_vec),  32'(exp_vec));
    check_val({tag, "_cnt"},  32'(hit_cnt),  (exp_cnt > 255) ? 32'd255 : 32'(exp_cnt));
    check_val({tag, "_scnt"}, 32'(s_cnt),    (exp_cnt > 3)   ? 32'd3   : 32'(exp_cnt));
    check_val({tag, "_svec"}, 32'(s_vec),    32'(exp_vec));
    if (flag_out === 1'b1) flag_seen++;
  endtask

  // driver: one clock cycle of stimulus, then compare after the edge
  task automatic step(input string tag, input logic v, input logic [IN_W-1:0] d, input logic c);
    @(negedge clk);
    valid   = v;
    data_in = d;
    clr     = c;
    if (c) model_clear();
    else if (v) model_beat(d);
    else begin
      exp_vec  = '0;
      exp_flag = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic restart(input logic [SEQ_LEN-1:0] p, input logic ov);
    @(negedge clk);
    pattern = p;
    overlap = ov;
    step("clr", 1'b0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] d;
    int pi;

    // reset
    model_clear();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: 10,11,00,10 overlapping
    restart(7'b1011001, 1'b1);
    step("t1", 1'b1, 2'b10, 1'b0);
    step("t1", 1'b1, 2'b11, 1'b0);
    step("t1", 1'b1, 2'b00, 1'b0);
    step("t1", 1'b1, 2'b10, 1'b0);
    check_val("t1_vec_const",  32'(hit_vec),  32'h2);
    check_val("t1_flag_const", 32'(flag_out), 32'h1);
    check_val("t1_cnt_const",  32'(hit_cnt),  32'h1);

    // async reset while outputs are non-zero
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    model_clear();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // partial history from before the reset must not complete a match
    step("post_rst", 1'b1, 2'b11, 1'b0);
    step("post_rst", 1'b1, 2'b00, 1'b0);
    step("post_rst", 1'b1, 2'b10, 1'b0);
    check_val("post_rst_cnt", 32'(hit_cnt), 32'h0);

    // T2: idle gaps between beats
    restart(7'b1011001, 1'b1);
    flag_seen = 0;
    step("t2", 1'b1, 2'b10, 1'b0);
    step("t2", 1'b0, 2'b01, 1'b0);
    step("t2", 1'b1, 2'b11, 1'b0);
    step("t2", 1'b0, 2'b10, 1'b0);
    step("t2", 1'b0, 2'b10, 1'b0);
    step("t2", 1'b1, 2'b00, 1'b0);
    step("t2", 1'b0, 2'b11, 1'b0);
    step("t2", 1'b1, 2'b10, 1'b0);
    check_val("t2_vec_const", 32'(hit_vec), 32'h2);
    step("t2", 1'b0, 2'b00, 1'b0);
    check_val("t2_flags", 32'(flag_seen), 32'h1);

    // T3: self-similar pattern, overlapping
    restart(7'b1111111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("t3", 1'b1, 2'b11, 1'b0);
      if (i >= 3) check_val("t3_vec_const", 32'(hit_vec), 32'h3);
    end
    check_val("t3_cnt_const",  32'(hit_cnt), 32'd10);
    check_val("t3_scnt_const", 32'(s_cnt),   32'd3);

    // T4: same stream, non-overlapping
    restart(7'b1111111, 1'b0);
    flag_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step("t4", 1'b1, 2'b11, 1'b0);
      if (i == 3) check_val("t4_first_vec", 32'(hit_vec), 32'h2);
    end
    check_val("t4_cnt_const", 32'(hit_cnt), 32'd2);
    check_val("t4_flags", 32'(flag_seen), 32'd2);

    // T5: clr with a beat discards that beat and the history
    restart(7'b1011001, 1'b1);
    step("t5", 1'b1, 2'b10, 1'b0);
    step("t5", 1'b1, 2'b11, 1'b0);
    step("t5", 1'b1, 2'b00, 1'b0);
    step("t5_clr", 1'b1, 2'b10, 1'b1);
    step("t5", 1'b1, 2'b10, 1'b0);
    step("t5", 1'b1, 2'b11, 1'b0);
    step("t5", 1'b1, 2'b00, 1'b0);
    step("t5", 1'b1, 2'b10, 1'b0);
    check_val("t5_cnt_const", 32'(hit_cnt), 32'h1);

    // randomized traffic, stream biased toward the pattern so hits happen
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0: restart(7'b1111111, 1'($urandom_range(0, 1)));
        1: restart(7'b1010101, 1'($urandom_range(0, 1)));
        default: restart(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      endcase
      pi = 0;
      for (int n = 0; n < 120; n++) begin
        if ($urandom_range(0, 4) == 0) begin
          step("rnd_idle", 1'b0, 2'($urandom_range(0, 3)), 1'b0);
        end else if ($urandom_range(0, 59) == 0) begin
          step("rnd_clr", 1'b1, 2'($urandom_range(0, 3)), 1'b1);
        end else begin
          for (int b = IN_W - 1; b >= 0; b--) begin
            if ($urandom_range(0, 7) == 0) d[b] = 1'($urandom_range(0, 1));
            else d[b] = pattern[SEQ_LEN-1-pi];
            pi = (pi + 1) % SEQ_LEN;
          end
          step("rnd", 1'b1, d, 1'b0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
